mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: MAX_D_BURST, default 4, max consecutive data grants while an instruction request waits (legal range 1..15).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 i_read  input  1  fetch-stage read request; held high until i_resp.
REQ-005 i_address  input  16  fetch address (lc3b_word).
REQ-006 i_rdata  output  16  instruction read data; valid while i_resp=1.
REQ-007 i_resp  output  1  one-cycle completion pulse to fetch stage.
REQ-008 d_read / d_write  input  1 each  MEM-stage requests; held until d_resp.
REQ-009 d_wmask  input  2  byte-enable mask for writes (lc3b_mem_wmask).
REQ-010 d_address / d_wdata  input  16 each  data address and write data.
REQ-011 d_rdata  output  16  data read result; valid while d_resp=1.
REQ-012 d_resp  output  1  one-cycle completion pulse to MEM stage.
REQ-013 pmem_read / pmem_write  output  1 each  physical memory strobes.
REQ-014 pmem_wmask  output  2; pmem_address / pmem_wdata  output  16 each.
REQ-015 pmem_rdata  input  16; pmem_resp  input  1  physical memory completion.

Function
REQ-016 FSM states: IDLE, I_BUSY, D_BUSY, I_DONE, D_DONE.
REQ-017 IDLE, no request: remain in IDLE with all strobes low.
REQ-018 IDLE, request present: grant exactly one client, latch its address, data, mask and op into registers, and move to I_BUSY or D_BUSY.
REQ-019 Priority rule: data wins over instruction, except when i_read=1 and d_streak==MAX_D_BURST; in that case instruction wins.
REQ-020 d_streak (4-bit) rules:
- increments on a data grant made while i_read=1;
- clears on any instruction grant;
- clears on a data grant made while i_read=0;
- saturates at MAX_D_BURST.
REQ-021 In I_BUSY/D_BUSY, pmem outputs are driven from the latched registers and stay stable until pmem_resp.
REQ-022 Client input changes mid-transaction have no effect, including a dropped request; the transaction still completes and its resp still pulses.
REQ-023 On pmem_resp in I_BUSY: register pmem_rdata into i_rdata, go to I_DONE, deassert pmem strobes. D_BUSY/D_DONE behave identically on the data side.
REQ-024 I_DONE / D_DONE: assert the matching resp for exactly one cycle, then return to IDLE unconditionally. No grant is made in the DONE cycle.
REQ-025 Latency: grant at edge k puts the pmem strobe high in cycle k+1. pmem_resp sampled at edge m gives client resp in cycle m+1 and IDLE at edge m+2. Minimum request-to-resp is 3 cycles.
REQ-026 d_read and d_write both high: treat as a write, ignore the read, and assert pmem_read=0.
REQ-027 Read-mask rule: pmem_wmask is 2'b00 on reads and equals the latched d_wmask on writes.
REQ-028 pmem_resp in IDLE or a DONE state is ignored.
REQ-029 pmem_read and pmem_write are never high simultaneously, and never high outside the BUSY states.
REQ-030 i_rdata and d_rdata hold their last captured value between responses.

Reset
REQ-031 rst_n=0 forces, immediately and independent of clk:
- state=IDLE, d_streak=0;
- all strobes, resp outputs, rdata outputs, pmem_address, pmem_wdata and pmem_wmask = 0.
REQ-032 Reset mid-transaction aborts it: no resp is issued and clients must re-request. A pmem_resp arriving after reset release is ignored under REQ-028.

Structure
REQ-033 Shared package lc3b_types: lc3b_word, lc3b_mem_wmask (2-bit), and the arbiter state enum lc3b_arb_state.
REQ-034 Module organisation: single module, FSM next-state logic and request latch registers inline; no sub-module required.

Verification
REQ-035 Single fetch: i_read, i_address=16'h0040, pmem_resp 2 cycles after pmem_read rises, pmem_rdata=16'h1234 -> pmem_address=16'h0040, one i_resp pulse with i_rdata=16'h1234, d_resp never asserted.
REQ-036 Simultaneous i_read and d_write (d_address=16'h0100, d_wdata=16'hBEEF, d_wmask=2'b01) -> data served first with pmem_write=1 and pmem_wmask=2'b01; instruction served afterwards.
REQ-037 Starvation: i_read held while d_read is re-asserted after every d_resp, MAX_D_BURST=4 -> exactly 4 data transactions, then an instruction grant, then d_streak=0.
REQ-038 d_read and d_write both high -> pmem_write=1, pmem_read=0, one d_resp.
REQ-039 rst_n pulsed low during D_BUSY -> outputs zero asynchronously, no d_resp; a later pmem_resp in IDLE is ignored; a fresh d_read completes normally.
REQ-040 Assertions checked on every cycle of all scenarios: REQ-029 strobe exclusivity; resp width is exactly one cycle; pmem outputs stable throughout BUSY states.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b memory types and the arbiter state encoding.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic [2:0] {
    IDLE,
    I_BUSY,
    D_BUSY,
    I_DONE,
    D_DONE
  } lc3b_arb_state;

  localparam int unsigned STREAK_W = 4;

  // Request captured at grant time; drives the pmem port for the whole transaction.
  typedef struct packed {
    lc3b_word      addr;
    lc3b_word      wdata;
    lc3b_mem_wmask wmask;
    logic          write;
  } mem_req_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-client (fetch/MEM) arbiter onto one physical memory port, data-priority with starvation cap.
// Latency: grant edge -> pmem strobe next cycle; pmem_resp edge -> one-cycle client resp, then IDLE.
// Backpressure: clients hold requests until resp; pmem stalls by withholding pmem_resp.
module mem_arbiter
  import lc3b_types::*;
#(
  parameter int unsigned MAX_D_BURST = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_read,
  input  lc3b_word      i_address,
  output lc3b_word      i_rdata,
  output logic          i_resp,
  input  logic          d_read,
  input  logic          d_write,
  input  lc3b_mem_wmask d_wmask,
  input  lc3b_word      d_address,
  input  lc3b_word      d_wdata,
  output lc3b_word      d_rdata,
  output logic          d_resp,
  output logic          pmem_read,
  output logic          pmem_write,
  output lc3b_mem_wmask pmem_wmask,
  output lc3b_word      pmem_address,
  output lc3b_word      pmem_wdata,
  input  lc3b_word      pmem_rdata,
  input  logic          pmem_resp
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_BURST);

  lc3b_arb_state       state, state_nxt;
  logic [STREAK_W-1:0] d_streak, d_streak_nxt;
  mem_req_t            req_q, req_nxt;
  logic                d_req, i_wins, grant_i, grant_d;

  assign d_req  = d_read | d_write;
  // Instruction only overtakes data once the data streak has hit its cap.
  assign i_wins = i_read & (~d_req | (d_streak == STREAK_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_wins) begin
          state_nxt = I_BUSY;
          grant_i   = 1'b1;
        end else if (d_req) begin
          state_nxt = D_BUSY;
          grant_d   = 1'b1;
        end
      end
      I_BUSY:  if (pmem_resp) state_nxt = I_DONE;
      D_BUSY:  if (pmem_resp) state_nxt = D_DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    d_streak_nxt = d_streak;
    if (grant_i) begin
      d_streak_nxt = '0;
    end else if (grant_d) begin
      if (!i_read)                    d_streak_nxt = '0;
      else if (d_streak < STREAK_MAX) d_streak_nxt = d_streak + 1'b1;
    end
  end

  // Write wins when both data ops are raised; reads always carry an empty mask.
  always_comb begin
    req_nxt = req_q;
    if (grant_i)
      req_nxt = '{addr: i_address, wdata: '0, wmask: '0, write: 1'b0};
    else if (grant_d)
      req_nxt = '{addr: d_address, wdata: d_wdata,
                  wmask: d_write ? d_wmask : 2'b00, write: d_write};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_streak <= '0;
      req_q    <= '0;
      i_rdata  <= '0;
      d_rdata  <= '0;
    end else begin
      d_streak <= d_streak_nxt;
      req_q    <= req_nxt;
      if (state == I_BUSY && pmem_resp) i_rdata <= pmem_rdata;
      if (state == D_BUSY && pmem_resp) d_rdata <= pmem_rdata;
    end
  end

  assign pmem_read    = (state == I_BUSY) | ((state == D_BUSY) & ~req_q.write);
  assign pmem_write   = (state == D_BUSY) & req_q.write;
  assign pmem_address = req_q.addr;
  assign pmem_wdata   = req_q.wdata;
  assign pmem_wmask   = req_q.wmask;
  assign i_resp       = (state == I_DONE);
  assign d_resp       = (state == D_DONE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, corner sequences, randomized run against a transaction model.
module tb_mem_arbiter;

  localparam int MAXB = 4;
  localparam int P_FREE = 0, P_BUSY = 1, P_DONE = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        i_read = 1'b0, d_read = 1'b0, d_write = 1'b0, pmem_resp = 1'b0;
  logic [15:0] i_address = '0, d_address = '0, d_wdata = '0, pmem_rdata = '0;
  logic [1:0]  d_wmask = '0;
  logic [15:0] i_rdata, d_rdata, pmem_address, pmem_wdata;
  logic [1:0]  pmem_wmask;
  logic        i_resp, d_resp, pmem_read, pmem_write;

  mem_arbiter #(.MAX_D_BURST(MAXB)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_wmask(d_wmask), .d_address(d_address),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_wmask(pmem_wmask),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; pmem_resp = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Wait (bounded) for the next pmem transaction, answer it, check the client response.
  task automatic serve(input string nm, input bit exp_i, input bit exp_wr,
                       input logic [15:0] exp_addr, input logic [15:0] rd);
    int n = 0;
    while (!(pmem_read | pmem_write) && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (!(pmem_read | pmem_write)) begin
      chk({nm, ".grant_timeout"}, 0, 1);
      return;
    end
    chk({nm, ".pmem_write"}, pmem_write, exp_wr);
    chk({nm, ".pmem_read"}, pmem_read, !exp_wr);
    chk({nm, ".addr"}, pmem_address, exp_addr);
    pmem_resp = 1'b1; pmem_rdata = rd;
    @(negedge clk);
    pmem_resp = 1'b0;
    chk({nm, ".i_resp"}, i_resp, exp_i);
    chk({nm, ".d_resp"}, d_resp, !exp_i);
    if (exp_i) begin
      chk({nm, ".i_rdata"}, i_rdata, rd);
      i_read = 1'b0;
    end else begin
      if (!exp_wr) chk({nm, ".d_rdata"}, d_rdata, rd);
      d_read = 1'b0; d_write = 1'b0;
    end
  endtask

  // Cycle invariants: strobe exclusivity, one-cycle responses, pmem stability while busy.
  logic p_rd = 0, p_wr = 0, p_ir = 0, p_dr = 0, p_rst = 0;
  logic [15:0] p_addr = '0, p_wd = '0;
  logic [1:0]  p_wm = '0;
  always @(negedge clk) begin
    if (rst_n && p_rst) begin
      chk("mon.strobe_excl", pmem_read & pmem_write, 0);
      if (p_ir) chk("mon.i_resp_width", i_resp, 0);
      if (p_dr) chk("mon.d_resp_width", d_resp, 0);
      if ((p_rd | p_wr) && (pmem_read | pmem_write))
        chk("mon.busy_stable", {pmem_read, pmem_write, pmem_wmask, pmem_address, pmem_wdata},
            {p_rd, p_wr, p_wm, p_addr, p_wd});
    end
    p_rst = rst_n; p_rd = pmem_read; p_wr = pmem_write; p_ir = i_resp; p_dr = d_resp;
    p_addr = pmem_address; p_wd = pmem_wdata; p_wm = pmem_wmask;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        i_rd, d_rd, d_wr;
    logic [1:0]  wm;
    logic [15:0] ia, da, dw, rdata;
    int          delay;
    logic        exp_rd, exp_wr;
    logic [1:0]  exp_wm;
    logic [15:0] exp_addr, exp_wd;
    logic        exp_i;
  } vec_t;

  localparam int NV = 7;
  vec_t vt [NV];

  // Random-phase model state
  int          phase, streak, op;
  bit          owner_i, e_wr, win_i, ip, dp;
  logic [15:0] e_addr, e_wd, last_i, last_d;
  logic [1:0]  e_wm;
  logic        s_ir, s_dr, s_dw, s_pr;
  logic [15:0] s_ia, s_da, s_dwd, s_prd;
  logic [1:0]  s_wm;

  initial begin
    //        i  d  dw wm     ia        da        dw        rdata     dly rd wr ewm    eaddr     ewd       ei
    vt[0] = '{1, 0, 0, 2'b00, 16'h0040, 16'h0000, 16'h0000, 16'h1234, 2,  1, 0, 2'b00, 16'h0040, 16'h0000, 1};
    vt[1] = '{0, 1, 0, 2'b11, 16'h0000, 16'h0200, 16'hFFFF, 16'h5A5A, 1,  1, 0, 2'b00, 16'h0200, 16'h0000, 0};
    vt[2] = '{0, 0, 1, 2'b01, 16'h0000, 16'h0100, 16'hBEEF, 16'h0000, 0,  0, 1, 2'b01, 16'h0100, 16'hBEEF, 0};
    vt[3] = '{0, 1, 1, 2'b10, 16'h0000, 16'h0300, 16'hCAFE, 16'h7777, 1,  0, 1, 2'b10, 16'h0300, 16'hCAFE, 0};
    vt[4] = '{1, 0, 1, 2'b01, 16'h0040, 16'h0100, 16'hBEEF, 16'h0000, 0,  0, 1, 2'b01, 16'h0100, 16'hBEEF, 0};
    vt[5] = '{1, 1, 0, 2'b11, 16'h0044, 16'h0208, 16'h0000, 16'h9999, 3,  1, 0, 2'b00, 16'h0208, 16'h0000, 0};
    vt[6] = '{1, 0, 0, 2'b11, 16'hFFFE, 16'h1111, 16'h2222, 16'h0001, 0,  1, 0, 2'b00, 16'hFFFE, 16'h0000, 1};

    // Asynchronous reset with no clock edge in between
    #2 rst_n = 1'b0;
    #1;
    chk("reset.strobes", {pmem_read, pmem_write}, 0);
    chk("reset.resps", {i_resp, d_resp}, 0);
    chk("reset.rdata", {i_rdata, d_rdata}, 0);
    chk("reset.pmem_bus", {pmem_address, pmem_wdata, pmem_wmask}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset.idle_no_req", pmem_read | pmem_write, 0);

    for (int v = 0; v < NV; v++) begin
      do_reset();
      i_read = vt[v].i_rd; d_read = vt[v].d_rd; d_write = vt[v].d_wr; d_wmask = vt[v].wm;
      i_address = vt[v].ia; d_address = vt[v].da; d_wdata = vt[v].dw;
      @(negedge clk);
      chk($sformatf("vec%0d.pmem_read", v), pmem_read, vt[v].exp_rd);
      chk($sformatf("vec%0d.pmem_write", v), pmem_write, vt[v].exp_wr);
      chk($sformatf("vec%0d.pmem_wmask", v), pmem_wmask, vt[v].exp_wm);
      chk($sformatf("vec%0d.pmem_address", v), pmem_address, vt[v].exp_addr);
      if (vt[v].exp_wr) chk($sformatf("vec%0d.pmem_wdata", v), pmem_wdata, vt[v].exp_wd);
      repeat (vt[v].delay) @(negedge clk);
      pmem_resp = 1'b1; pmem_rdata = vt[v].rdata;
      @(negedge clk);
      pmem_resp = 1'b0;
      chk($sformatf("vec%0d.i_resp", v), i_resp, vt[v].exp_i);
      chk($sformatf("vec%0d.d_resp", v), d_resp, !vt[v].exp_i);
      if (vt[v].exp_rd)
        chk($sformatf("vec%0d.rdata", v), vt[v].exp_i ? i_rdata : d_rdata, vt[v].rdata);
      chk($sformatf("vec%0d.strobes_done", v), pmem_read | pmem_write, 0);
      i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d.resp_after", v), i_resp | d_resp, 0);
    end

    // Data write beats a simultaneous fetch; fetch follows
    do_reset();
    i_read = 1'b1; i_address = 16'h0040;
    d_write = 1'b1; d_address = 16'h0100; d_wdata = 16'hBEEF; d_wmask = 2'b01;
    serve("both.d", 0, 1, 16'h0100, 16'h0000);
    serve("both.i", 1, 0, 16'h0040, 16'h1234);

    // Starvation cap: MAXB data grants, then the fetch, then the streak restarts
    do_reset();
    i_read = 1'b1; i_address = 16'h0A00;
    d_read = 1'b1; d_address = 16'h0D00;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < MAXB; k++) begin
        serve($sformatf("starve.r%0d.d%0d", r, k), 0, 0, d_address, 16'h3000 + 16'(k));
        d_read = 1'b1;
        d_address = d_address + 16'h1;
      end
      serve($sformatf("starve.r%0d.i", r), 1, 0, i_address, 16'h0B00 + 16'(r));
      if (r == 0) begin
        i_read = 1'b1; i_address = 16'h0A02;
      end
    end

    // Reset in D_BUSY: async clear, no resp, stray pmem_resp ignored, fresh request works
    d_address = 16'h0777;
    for (int n = 0; n < 6 && !(pmem_read | pmem_write); n++) @(negedge clk);
    chk("rst.busy_before", pmem_read, 1);
    #2 rst_n = 1'b0; d_read = 1'b0;
    #1;
    chk("rst.strobes", {pmem_read, pmem_write}, 0);
    chk("rst.pmem_bus", {pmem_address, pmem_wdata, pmem_wmask}, 0);
    chk("rst.resps", {i_resp, d_resp}, 0);
    chk("rst.rdata", {i_rdata, d_rdata}, 0);
    @(negedge clk);
    rst_n = 1'b1; pmem_resp = 1'b1; pmem_rdata = 16'hDEAD;
    @(negedge clk);
    pmem_resp = 1'b0;
    chk("rst.stray_resp", {i_resp, d_resp}, 0);
    chk("rst.stray_strobe", pmem_read | pmem_write, 0);
    @(negedge clk);
    chk("rst.stray_resp2", {i_resp, d_resp}, 0);
    chk("rst.stray_rdata", d_rdata, 0);
    d_read = 1'b1; d_address = 16'h0778;
    serve("rst.fresh", 0, 0, 16'h0778, 16'h4321);

    // Randomized traffic against a transaction-level model
    do_reset();
    phase = P_FREE; streak = 0; ip = 0; dp = 0; owner_i = 0; e_wr = 0;
    e_addr = '0; e_wd = '0; e_wm = '0; last_i = '0; last_d = '0;
    s_ir = 0; s_dr = 0; s_dw = 0; s_pr = 0; s_ia = '0; s_da = '0; s_dwd = '0; s_prd = '0; s_wm = '0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      case (phase)
        P_FREE: begin
          if (s_ir | s_dr | s_dw) begin
            win_i = s_ir && (!(s_dr | s_dw) || streak == MAXB);
            owner_i = win_i;
            if (win_i) begin
              e_wr = 0; e_addr = s_ia; e_wm = 2'b00; streak = 0;
            end else begin
              e_wr = s_dw; e_addr = s_da; e_wd = s_dwd; e_wm = s_dw ? s_wm : 2'b00;
              streak = s_ir ? ((streak < MAXB) ? streak + 1 : MAXB) : 0;
            end
            chk("rand.grant_read", pmem_read, !e_wr);
            chk("rand.grant_write", pmem_write, e_wr);
            chk("rand.grant_addr", pmem_address, e_addr);
            chk("rand.grant_wmask", pmem_wmask, e_wm);
            if (e_wr) chk("rand.grant_wdata", pmem_wdata, e_wd);
            phase = P_BUSY;
          end else begin
            chk("rand.idle_strobe", pmem_read | pmem_write, 0);
          end
        end
        P_BUSY: begin
          if (s_pr) begin
            chk("rand.i_resp", i_resp, owner_i);
            chk("rand.d_resp", d_resp, !owner_i);
            chk("rand.done_strobe", pmem_read | pmem_write, 0);
            if (owner_i) begin
              last_i = s_prd; ip = 0; i_read = 1'b0;
            end else begin
              last_d = s_prd; dp = 0; d_read = 1'b0; d_write = 1'b0;
            end
            phase = P_DONE;
          end else begin
            chk("rand.busy_strobe", pmem_read | pmem_write, 1);
            chk("rand.busy_addr", pmem_address, e_addr);
          end
        end
        default: begin
          chk("rand.after_resp", {i_resp, d_resp, pmem_read, pmem_write}, 0);
          phase = P_FREE;
        end
      endcase
      chk("rand.i_rdata", i_rdata, last_i);
      chk("rand.d_rdata", d_rdata, last_d);

      // Granted client disturbs its inputs mid-transaction
      if (phase == P_BUSY && $urandom_range(0, 7) == 0) begin
        if (owner_i) begin
          i_address = 16'($urandom);
          if ($urandom_range(0, 1) == 0) i_read = 1'b0;
        end else begin
          d_address = 16'($urandom); d_wdata = 16'($urandom); d_wmask = 2'($urandom);
          if ($urandom_range(0, 1) == 0) begin d_read = 1'b0; d_write = 1'b0; end
        end
      end
      if (!ip && $urandom_range(0, 2) == 0) begin
        ip = 1; i_read = 1'b1; i_address = 16'($urandom);
      end
      if (!dp && $urandom_range(0, 1) == 0) begin
        dp = 1; op = int'($urandom_range(0, 2));
        d_read = (op != 1); d_write = (op != 0);
        d_address = 16'($urandom); d_wdata = 16'($urandom); d_wmask = 2'($urandom);
      end
      pmem_resp = (phase == P_BUSY) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 5) == 0);
      pmem_rdata = 16'($urandom);

      s_ir = i_read; s_dr = d_read; s_dw = d_write; s_pr = pmem_resp;
      s_ia = i_address; s_da = d_address; s_dwd = d_wdata; s_wm = d_wmask; s_prd = pmem_rdata;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
